pulse_meter: RTL

Measures an external square wave of the kind our PWM/glitch generators produce on an output pin. Reports high-phase and low-phase durations in `clk` ticks and counts glitch segments, meaning phases shorter than a configured threshold. It also flags a stalled input. It sits on the capture side of the Mojo test setup, where it checks generator output in loopback or monitors a target's clock/enable line during glitch campaigns.

---
 rtl/pulse_meter_pkg.sv | 12 +
 rtl/sync_edge.sv | 32 +++
 rtl/pulse_meter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse_meter capture block.
package pulse_meter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEAS_HIGH,
      MEAS_LOW
   } state_t;

   localparam int unsigned GCOUNT_W = 8;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus rise/fall detection on
// the synchronized level.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sig_m;
   logic sig_s;
   logic sig_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_m <= 1'b0;
         sig_s <= 1'b0;
         sig_d <= 1'b0;
      end else begin
         sig_m <= sig_in;
         sig_s <= sig_m;
         sig_d <= sig_s;
      end
   end

   assign level = sig_s;
   assign rise  = sig_s & ~sig_d;
   assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/pulse_meter.sv
// Measures high/low phase durations of an external square wave in clk ticks,
// counts glitch segments and flags a stalled input.
module pulse_meter
   import pulse_meter_pkg::*;
#(
   parameter int unsigned     CNT_W         = 32,
   parameter longint unsigned GLITCH_TICKS  = 1000,
   parameter longint unsigned TIMEOUT_TICKS = 50000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sig_in,
   input  logic                clear,
   output logic [CNT_W-1:0]    high_ticks,
   output logic [CNT_W-1:0]    low_ticks,
   output logic                valid,
   output logic                glitch_seen,
   output logic [GCOUNT_W-1:0] glitch_count,
   output logic                timeout,
   output logic                level
);

   localparam logic [CNT_W-1:0] GLITCH_LIM  = CNT_W'(GLITCH_TICKS);
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic             rise;
   logic             fall;
   logic             rise_e;
   logic             fall_e;
   logic [1:0]       warm;
   logic             primed;
   logic [CNT_W-1:0] cnt;
   state_t           state;
   state_t           state_nxt;
   logic             latch_high;
   logic             latch_low;
   logic             stall;
   logic             is_glitch;

   sync_edge u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   // The synchronizer leaves reset at 0, so a high input looks like a rise
   // until both flops and the delay stage hold real samples; mask that window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm <= '0;
      end else if (warm != 2'd3) begin
         warm <= warm + 2'd1;
      end
   end

   assign primed = (warm == 2'd3);
   assign rise_e = rise & primed & ~clear;
   assign fall_e = fall & primed & ~clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (rise_e || fall_e) begin
         cnt <= CNT_ONE;
      end else if (cnt != '1) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      latch_high = 1'b0;
      latch_low  = 1'b0;
      stall      = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (rise_e) begin
                  state_nxt = MEAS_HIGH;
               end
            end
            MEAS_HIGH: begin
               if (fall_e) begin
                  latch_high = 1'b1;
                  state_nxt  = MEAS_LOW;
               end else if (cnt == TIMEOUT_LIM) begin
                  stall     = 1'b1;
                  state_nxt = IDLE;
               end
            end
            MEAS_LOW: begin
               if (rise_e) begin
                  latch_low = 1'b1;
                  state_nxt = MEAS_HIGH;
               end else if (cnt == TIMEOUT_LIM) begin
                  stall     = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign is_glitch = (latch_high || latch_low) && (cnt < GLITCH_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_ticks   <= '0;
         low_ticks    <= '0;
         valid        <= 1'b0;
         glitch_seen  <= 1'b0;
         glitch_count <= '0;
         timeout      <= 1'b0;
      end else if (clear) begin
         high_ticks   <= '0;
         low_ticks    <= '0;
         valid        <= 1'b0;
         glitch_seen  <= 1'b0;
         glitch_count <= '0;
         timeout      <= 1'b0;
      end else begin
         valid <= latch_low;
         if (latch_high) begin
            high_ticks <= cnt;
         end
         if (latch_low) begin
            low_ticks <= cnt;
         end
         if (is_glitch) begin
            glitch_seen <= 1'b1;
            if (glitch_count != '1) begin
               glitch_count <= glitch_count + 1'b1;
            end
         end
         if (stall) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule
